// File: rtl/reaction_round_ctrl.sv
// Best-of-ROUNDS reaction game sequencer: random pre-delay, ms reaction
// timing, false-start retry, per-round result hold and best-time tracking.
module reaction_round_ctrl #(
  parameter int CYCLES_PER_MS = 100000,
  parameter int MIN_DELAY_MS  = 1000,
  parameter int RAND_BITS     = 10,
  parameter int RXN_MAX_MS    = 9999,
  parameter int SHOW_MS       = 2000,
  parameter int ROUNDS        = 3,
  parameter int TIME_W        = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       btn,
  output logic                       delay_flag,
  output logic                       led_flag,
  output logic                       rxn_flag,
  output logic                       false_start,
  output logic                       done,
  output logic [$clog2(ROUNDS+1)-1:0] round_num,
  output logic [TIME_W-1:0]          rxn_ms,
  output logic [TIME_W-1:0]          best_ms
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);
  localparam int SW = $clog2(SHOW_MS + 1);

  localparam logic [PW-1:0]     P_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [TIME_W-1:0] T_MAX  = TIME_W'(RXN_MAX_MS);
  localparam logic [DW-1:0]     D_MIN  = DW'(MIN_DELAY_MS);
  localparam logic [SW-1:0]     S_LEN  = SW'(SHOW_MS);
  localparam logic [RW-1:0]     R_LAST = RW'(ROUNDS - 1);

  // Encoding bits map straight onto the output flags:
  // {arm, delay, led, rxn, false_start, done}
  typedef enum logic [5:0] {
    IDLE        = 6'b000000,
    ARM         = 6'b100000,
    WAIT_DELAY  = 6'b010000,
    LED_ON      = 6'b001000,
    SHOW_ROUND  = 6'b000100,
    FALSE_START = 6'b000010,
    DONE        = 6'b000101
  } state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic                btn_q;
  logic [PW-1:0]       presc;
  logic [DW-1:0]       delay_cnt;
  logic [TIME_W-1:0]   rxn_cnt;
  logic [SW-1:0]       show_cnt;
  logic                tick;
  logic                press;

  assign tick  = (presc == P_LAST);
  assign press = btn & ~btn_q;

  assign delay_flag  = state[4];
  assign led_flag    = state[3];
  assign rxn_flag    = state[2];
  assign false_start = state[1];
  assign done        = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_num <= '0;
      rxn_ms    <= '0;
      best_ms   <= '0;
      presc     <= '0;
      btn_q     <= 1'b0;
      lfsr      <= 16'hACE1;
      delay_cnt <= '0;
      rxn_cnt   <= '0;
      show_cnt  <= '0;
    end else begin
      lfsr  <= {lfsr[14:0],
                lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      btn_q <= btn;
      presc <= tick ? '0 : presc + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            rxn_ms    <= '0;
            round_num <= '0;
            best_ms   <= T_MAX;
          end
        end

        ARM: begin
          delay_cnt <= D_MIN + DW'(lfsr[RAND_BITS-1:0]);
          presc     <= '0;
          state     <= WAIT_DELAY;
        end

        WAIT_DELAY: begin
          if (press) begin
            presc    <= '0;
            show_cnt <= S_LEN;
            state    <= FALSE_START;
          end else if (tick) begin
            if (delay_cnt == DW'(1)) begin
              presc   <= '0;
              rxn_cnt <= '0;
              state   <= LED_ON;
            end else begin
              delay_cnt <= delay_cnt - 1'b1;
            end
          end
        end

        LED_ON: begin
          // A press on a tick captures the pre-increment count.
          if (press || rxn_cnt == T_MAX) begin
            rxn_ms   <= rxn_cnt;
            best_ms  <= (rxn_cnt < best_ms) ? rxn_cnt : best_ms;
            presc    <= '0;
            show_cnt <= S_LEN;
            state    <= SHOW_ROUND;
          end else if (tick) begin
            rxn_cnt <= rxn_cnt + 1'b1;
          end
        end

        SHOW_ROUND: begin
          if (tick) begin
            if (show_cnt == SW'(1)) begin
              if (round_num == R_LAST) begin
                state <= DONE;
              end else begin
                round_num <= round_num + 1'b1;
                state     <= ARM;
              end
            end else begin
              show_cnt <= show_cnt - 1'b1;
            end
          end
        end

        FALSE_START: begin
          if (tick) begin
            if (show_cnt == SW'(1)) begin
              state <= ARM;
            end else begin
              show_cnt <= show_cnt - 1'b1;
            end
          end
        end

        DONE: begin
          if (start) begin
            state     <= ARM;
            round_num <= '0;
            best_ms   <= T_MAX;
            rxn_ms    <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomised scoreboard bench for reaction_round_ctrl: stimulus queues
// expected round/false-start results, a monitor checks them as they appear.
module tb_reaction_round_ctrl;

  localparam int CPM  = 4;
  localparam int TMAX = 20;
  localparam int SHOW_CYC = 3 * CPM;
  localparam int EV_ROUND = 0;
  localparam int EV_FALSE = 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       btn;
  logic       delay_flag;
  logic       led_flag;
  logic       rxn_flag;
  logic       false_start;
  logic       done;
  logic [1:0] round_num;
  logic [4:0] rxn_ms;
  logic [4:0] best_ms;

  reaction_round_ctrl #(
    .CYCLES_PER_MS(CPM),
    .MIN_DELAY_MS(2),
    .RAND_BITS(2),
    .RXN_MAX_MS(TMAX),
    .SHOW_MS(3),
    .ROUNDS(3),
    .TIME_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .btn(btn),
    .delay_flag(delay_flag),
    .led_flag(led_flag),
    .rxn_flag(rxn_flag),
    .false_start(false_start),
    .done(done),
    .round_num(round_num),
    .rxn_ms(rxn_ms),
    .best_ms(best_ms)
  );

  typedef struct {
    int kind;
    int rxn;
    int best;
    int rnd;
  } ev_t;

  ev_t q[$];
  ev_t cur;

  int vectors = 0;
  int miscompares = 0;

  int cur_best;
  int cur_rxn;
  int rnd;

  logic [15:0] m_lfsr;
  logic [15:0] lfsr_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: value during the ARM cycle sets the pre-delay.
  always @(posedge clk) begin
    lfsr_prev <= m_lfsr;
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0],
                        m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit flag(input int which);
    case (which)
      0:       return delay_flag;
      1:       return led_flag;
      default: return done;
    endcase
  endfunction

  task automatic wait_flag(input int which);
    int n;
    n = 0;
    while (!flag(which) && n < 200) begin
      step();
      n++;
    end
    if (!flag(which)) check("wait_flag_timeout", which, -1);
  endtask

  task automatic push_ev(input int kind, input int r, input int b,
                         input int n);
    ev_t e;
    e.kind = kind;
    e.rxn  = r;
    e.best = b;
    e.rnd  = n;
    q.push_back(e);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic new_game();
    start_pulse();
    cur_best = TMAX;
    cur_rxn  = 0;
    rnd      = 0;
    check("arm_best", int'(best_ms), TMAX);
    check("arm_round", int'(round_num), 0);
    check("arm_rxn", int'(rxn_ms), 0);
    check("arm_done", int'(done), 0);
  endtask

  function automatic int expect_rxn(input int c);
    if (c < 0) return TMAX;
    return (c / CPM > TMAX) ? TMAX : c / CPM;
  endfunction

  task automatic record_round(input int e);
    if (e < cur_best) cur_best = e;
    cur_rxn = e;
    push_ev(EV_ROUND, e, cur_best, rnd);
  endtask

  task automatic finish_round();
    int n;
    n = 0;
    while (led_flag && n < 100) begin
      step();
      n++;
    end
    if (rnd < 2) rnd++;
  endtask

  // c = LED_ON cycle of the press (0 = entry cycle), c < 0 = never press
  task automatic do_round(input int c);
    wait_flag(1);
    record_round(expect_rxn(c));
    if (c >= 0) begin
      repeat (c) step();
      btn = 1'b1;
      step();
      btn = 1'b0;
    end
    finish_round();
  endtask

  // Button already high on LED entry: released at cycle r, re-pressed at c.
  task automatic do_held(input int r, input int c);
    wait_flag(1);
    record_round(expect_rxn(c));
    repeat (r) step();
    check("held_no_capture", int'(led_flag), 1);
    btn = 1'b0;
    repeat (c - r) step();
    btn = 1'b1;
    step();
    btn = 1'b0;
    finish_round();
  endtask

  task automatic do_false(input int k);
    wait_flag(0);
    push_ev(EV_FALSE, cur_rxn, cur_best, rnd);
    repeat (k) step();
    btn = 1'b1;
    step();
    btn = 1'b0;
  endtask

  task automatic pop_ev(input int kind);
    if (q.size() == 0) begin
      check("event_queued", 0, 1);
    end else begin
      cur = q.pop_front();
      check("event_kind", cur.kind, kind);
    end
  endtask

  // Monitor
  bit p_dly, p_rxn, p_fs, p_done;
  int dly_len, exp_dly, rxn_len, fs_len;

  initial begin
    p_dly = 0; p_rxn = 0; p_fs = 0; p_done = 0;
    dly_len = 0; exp_dly = 0; rxn_len = 0; fs_len = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        p_dly = 0; p_rxn = 0; p_fs = 0; p_done = 0;
      end else begin
        if (delay_flag && !p_dly) begin
          dly_len = 0;
          exp_dly = CPM * (2 + int'(lfsr_prev[1:0]));
        end
        if (delay_flag) dly_len++;
        if (p_dly && !delay_flag && led_flag)
          check("wait_len", dly_len, exp_dly);

        if (rxn_flag && !p_rxn) begin
          rxn_len = 0;
          pop_ev(EV_ROUND);
          check("round_rxn", int'(rxn_ms), cur.rxn);
          check("round_best", int'(best_ms), cur.best);
          check("round_num_show", int'(round_num), cur.rnd);
        end
        if (rxn_flag && !done) rxn_len++;
        if (p_rxn && !p_done && (!rxn_flag || done)) begin
          check("show_len", rxn_len, SHOW_CYC);
          check("done_on_last", int'(done), int'(cur.rnd == 2));
          check("round_after", int'(round_num),
                (cur.rnd == 2) ? 2 : cur.rnd + 1);
        end

        if (false_start && !p_fs) begin
          fs_len = 0;
          pop_ev(EV_FALSE);
          check("fs_round", int'(round_num), cur.rnd);
          check("fs_best", int'(best_ms), cur.best);
          check("fs_rxn", int'(rxn_ms), cur.rxn);
        end
        if (false_start) fs_len++;
        if (p_fs && !false_start) begin
          check("fs_len", fs_len, SHOW_CYC);
          check("fs_round_after", int'(round_num), cur.rnd);
        end

        p_dly  = delay_flag;
        p_rxn  = rxn_flag;
        p_fs   = false_start;
        p_done = done;
      end
    end
  end

  // Stimulus
  initial begin
    int bad;
    rst = 1'b1;
    start = 1'b0;
    btn = 1'b0;
    cur_best = 0;
    cur_rxn = 0;
    rnd = 0;

    repeat (3) step();
    check("reset_outputs",
          int'({delay_flag, led_flag, rxn_flag, false_start, done,
                round_num, rxn_ms, best_ms}), 0);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      step();
      if ({delay_flag, led_flag, rxn_flag, false_start, done,
           round_num, rxn_ms, best_ms} != '0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Game 1: normal, false start, timeout, tick/press coincidence
    new_game();
    do_round(20);
    do_false(4);
    do_round(-1);
    do_round(31);
    wait_flag(2);
    check("g1_best", int'(best_ms), 5);
    check("g1_round", int'(round_num), 2);
    check("g1_rxn", int'(rxn_ms), 7);

    // Game 2: 9, 4, 6
    new_game();
    do_round(36);
    do_round(16);
    do_round(24);
    wait_flag(2);
    check("g2_best", int'(best_ms), 4);
    check("g2_done", int'(done), 1);
    check("g2_round", int'(round_num), 2);

    // Game 3: held button across entry, then randomised play
    btn = 1'b1;
    step();
    new_game();
    do_held(10, 14);
    do_false($urandom_range(0, 7));
    do_round($urandom_range(0, 80));
    do_round($urandom_range(0, 80));
    wait_flag(2);
    check("g3_best", int'(best_ms), cur_best);
    check("g3_round", int'(round_num), 2);

    // Game 4: reset while LED is on
    new_game();
    wait_flag(1);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("rst_mid_led", int'(led_flag), 0);
    check("rst_mid_best", int'(best_ms), 0);
    check("rst_mid_flags",
          int'({delay_flag, rxn_flag, false_start, done, round_num,
                rxn_ms}), 0);
    rst = 1'b0;
    repeat (20) step();
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
Multi-round sequencer for the reaction-speed game datapath. It runs a best-of-ROUNDS game: pseudo-random pre-delay, LED-on reaction timing in milliseconds, false-start detection with retry, per-round result hold, and best-time tracking. It drives the existing delay/LED/display flags, so the LED and 7-segment display logic attach unchanged.

Parameters:
CYCLES_PER_MS, 100000, clk cycles per 1 ms tick (100 MHz clock)
MIN_DELAY_MS, 1000, fixed part of the pre-LED delay
RAND_BITS, 10, number of LFSR LSBs added to the delay (0..2^RAND_BITS-1 ms)
RXN_MAX_MS, 9999, reaction counter saturation value and timeout
SHOW_MS, 2000, hold time for a round result or false-start indication
ROUNDS, 3, rounds per game (>=1)
TIME_W, 14, width of ms time values (must hold RXN_MAX_MS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  start request, level sampled each cycle; already synchronised
btn  in  1  reaction button, synchronised and debounced level
delay_flag  out  1  high in WAIT_DELAY
led_flag  out  1  high in LED_ON (drives the stimulus LED)
rxn_flag  out  1  high in SHOW_ROUND and DONE (display enable)
false_start  out  1  high in FALSE_START
done  out  1  high in DONE
round_num  out  $clog2(ROUNDS+1)  current round, 0-based
rxn_ms  out  TIME_W  last latched reaction time
best_ms  out  TIME_W  best reaction time this game

Behaviour:
- Synchronous reset (active-high): state=IDLE; all flags 0; round_num=0; rxn_ms=0; best_ms=0; prescaler=0; btn_q=0; LFSR=16'hACE1. Reset mid-game aborts to IDLE on the next edge.
- LFSR: 16-bit Fibonacci, shifts left every cycle in every state; bit0 <= q[15]^q[13]^q[12]^q[10].
- Button edge: btn_q registers btn; press = btn & ~btn_q. A button held across a state entry gives no press until it is released and pressed again.
- ms tick: prescaler counts 0..CYCLES_PER_MS-1 and is cleared on entry to WAIT_DELAY, LED_ON, SHOW_ROUND and FALSE_START. tick=1 in the cycle the prescaler equals CYCLES_PER_MS-1.
- IDLE: start=1 -> ARM. rxn_ms and round_num are cleared, best_ms=RXN_MAX_MS.
- ARM (1 cycle): delay_cnt <= MIN_DELAY_MS + LFSR[RAND_BITS-1:0]; -> WAIT_DELAY.
- WAIT_DELAY: on tick, delay_cnt decrements. On the tick where delay_cnt==1 -> LED_ON. press -> FALSE_START; press wins over expiry in the same cycle.
- LED_ON: rxn_cnt=0 on entry. On tick, rxn_cnt increments, saturating at RXN_MAX_MS.
  - press -> rxn_ms <= rxn_cnt, using the pre-increment value if tick and press coincide; -> SHOW_ROUND.
  - rxn_cnt==RXN_MAX_MS with no press -> timeout: rxn_ms <= RXN_MAX_MS; -> SHOW_ROUND.
- SHOW_ROUND: best_ms <= min(best_ms, rxn_ms), applied on the entry cycle, unsigned compare; ties keep the old value. Stays for SHOW_MS ticks, then:
  - round_num==ROUNDS-1 -> DONE; round_num is not incremented.
  - otherwise round_num+1 -> ARM.
- FALSE_START: stays for SHOW_MS ticks; the same round_num retries -> ARM. rxn_ms and best_ms are unchanged.
- DONE: holds rxn_ms, best_ms and round_num. start=1 -> ARM with round_num=0, best_ms=RXN_MAX_MS, rxn_ms=0.
- start is ignored outside IDLE and DONE. btn is ignored outside WAIT_DELAY and LED_ON.
- Flags are decoded from state registers only (glitch-free). Exactly one of delay_flag/led_flag/false_start/SHOW_ROUND is high at a time; DONE asserts rxn_flag and done together.
- Unreachable state encodings -> IDLE on the next edge.

Test Plan:
Use CYCLES_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2, RXN_MAX_MS=20, SHOW_MS=3, ROUNDS=3, TIME_W=5. The bench models the LFSR to predict the delay.
- Reset/idle: hold rst 3 cycles -> all outputs 0; start low 50 cycles -> stays IDLE, flags 0.
- Normal round: start pulse -> delay_flag for exactly 4*(2+LFSR[1:0]) cycles after ARM -> led_flag; press after 5 ticks -> rxn_ms=5, best_ms=5, rxn_flag for 12 cycles, round_num=1.
- False start: press 1 tick into WAIT_DELAY -> false_start for 12 cycles, round_num unchanged, best_ms unchanged, new delay loaded.
- Timeout and coincidence: no press -> rxn_ms=20 after 20 ticks. Press in the same cycle as a tick at count 7 -> rxn_ms=7.
- Full game: times 9, 4, 6 -> best_ms=4, done=1, round_num=2. start in DONE -> new game with best_ms=20 and round_num=0. btn held high across LED_ON entry -> no capture until release and re-press.
- Reset mid-LED_ON: rst for 1 cycle -> IDLE, led_flag=0, best_ms=0 on the next edge.
